// File: rtl/aes256_roundkey_store_pkg.sv
// AES-256 round-key constants and FSM state encodings, shared between the key
// expansion engine, this round-key store and the round datapath.
package aes256_roundkey_store_pkg;

  localparam int         RK_NKEYS = 15;
  localparam int         RK_KW    = 128;
  localparam logic [3:0] RK_LAST  = 4'd14;

  typedef enum logic [1:0] {
    CAP_EMPTY = 2'd0,
    CAP_LOAD  = 2'd1,
    CAP_READY = 2'd2
  } cap_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_BUSY = 1'b1
  } rd_state_t;

endpackage

// File: rtl/aes256_roundkey_store_rk_regfile.sv
// Round-key register file: one synchronous write port, one combinational read
// port, and a synchronous clear that zeroes every entry.
module rk_regfile
  import aes256_roundkey_store_pkg::*;
#(
  parameter int DEPTH = RK_NKEYS,
  parameter int W     = RK_KW
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         we,
  input  logic [3:0]   waddr,
  input  logic [W-1:0] wdata,
  input  logic [3:0]   raddr,
  output logic [W-1:0] rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we && (32'(waddr) < DEPTH)) begin
      mem[waddr] <= wdata;
    end
  end

  // Out-of-range addresses only occur on the step past a terminal key, which is never used.
  assign rdata = (32'(raddr) < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/aes256_roundkey_store.sv
// AES-256 round-key capture/replay store. Optional build macro
// AES_RKSTORE_ZEROIZE_EN wipes keys on load_start and at the end of each pass.
module aes256_roundkey_store
  import aes256_roundkey_store_pkg::*;
#(
  parameter int NKEYS = RK_NKEYS,
  parameter int KW    = RK_KW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic [KW-1:0] skey_in,
  input  logic          skey_valid,
  output logic          ready,
  output logic          ovf,
  input  logic          rd_start,
  input  logic          rd_decrypt,
  input  logic          rd_next,
  output logic [KW-1:0] rk_out,
  output logic          rk_valid,
  output logic [3:0]    rk_idx,
  output logic          rd_done,
  output logic          rd_err
);

  localparam logic [3:0] LAST = 4'(NKEYS - 1);

  cap_state_t    cap_state, cap_ns;
  rd_state_t     rd_state, rd_ns;
  logic [3:0]    wptr, rptr, raddr;
  logic          rd_dir, wr_en, ovf_set;
  logic          accept, adv, last_key, pass_end, zclr, zero_end;
  logic [KW-1:0] rdata;

  // Optional key wipe: zero the store on reload and after each completed pass.
  always_comb begin
`ifdef AES_RKSTORE_ZEROIZE_EN
    zclr     = load_start || pass_end;
    zero_end = pass_end;
`else
    zclr     = 1'b0;
    zero_end = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cap_state <= CAP_EMPTY;
    else       cap_state <= cap_ns;
  end

  always_comb begin
    cap_ns = cap_state;
    if (load_start) begin
      cap_ns = CAP_LOAD;
    end else begin
      case (cap_state)
        CAP_LOAD:  if (skey_valid && wptr == LAST) cap_ns = CAP_READY;
        CAP_READY: if (zero_end) cap_ns = CAP_EMPTY;
        default:   cap_ns = cap_state;
      endcase
    end
  end

  always_comb begin
    ready   = (cap_state == CAP_READY);
    wr_en   = (cap_state == CAP_LOAD) && skey_valid && !load_start;
    ovf_set = (cap_state == CAP_READY) && skey_valid && !load_start;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      ovf  <= 1'b0;
    end else if (load_start) begin
      wptr <= '0;
      ovf  <= 1'b0;
    end else begin
      if (wr_en)   wptr <= wptr + 4'd1;
      if (ovf_set) ovf  <= 1'b1;
    end
  end

  // load_start outranks every replay action so capture and replay never overlap.
  always_comb begin
    accept   = rd_start && (rd_state == RD_IDLE) && ready && !load_start;
    adv      = (rd_state == RD_BUSY) && rd_next && !load_start;
    last_key = rd_dir ? (rptr == 4'd0) : (rptr == LAST);
    pass_end = adv && last_key;
    if (accept)      raddr = rd_decrypt ? LAST : 4'd0;
    else if (rd_dir) raddr = rptr - 4'd1;
    else             raddr = rptr + 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_state <= RD_IDLE;
    else       rd_state <= rd_ns;
  end

  always_comb begin
    rd_ns = rd_state;
    if (load_start)                          rd_ns = RD_IDLE;
    else if (rd_state == RD_IDLE && accept)  rd_ns = RD_BUSY;
    else if (rd_state == RD_BUSY && pass_end) rd_ns = RD_IDLE;
  end

  always_comb begin
    rk_valid = (rd_state == RD_BUSY);
    rk_idx   = rptr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rptr    <= '0;
      rd_dir  <= 1'b0;
      rk_out  <= '0;
      rd_done <= 1'b0;
      rd_err  <= 1'b0;
    end else begin
      rd_done <= pass_end;
      rd_err  <= rd_start && !accept;
      if (accept) begin
        rd_dir <= rd_decrypt;
        rptr   <= raddr;
        rk_out <= rdata;
      end else if (adv && !last_key) begin
        rptr   <= raddr;
        rk_out <= rdata;
      end
      if (zclr) rk_out <= '0;
    end
  end

  rk_regfile #(.DEPTH(NKEYS), .W(KW)) u_regfile (
    .clk   (clk),
    .reset (reset),
    .clr   (zclr),
    .we    (wr_en),
    .waddr (wptr),
    .wdata (skey_in),
    .raddr (raddr),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_aes256_roundkey_store.sv
// Directed bench for aes256_roundkey_store; honours AES_RKSTORE_ZEROIZE_EN when defined.
module tb_aes256_roundkey_store;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         load_start = 1'b0;
  logic [127:0] skey_in = '0;
  logic         skey_valid = 1'b0;
  logic         ready, ovf;
  logic         rd_start = 1'b0;
  logic         rd_decrypt = 1'b0;
  logic         rd_next = 1'b0;
  logic [127:0] rk_out;
  logic         rk_valid;
  logic [3:0]   rk_idx;
  logic         rd_done, rd_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes256_roundkey_store dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .skey_in    (skey_in),
    .skey_valid (skey_valid),
    .ready      (ready),
    .ovf        (ovf),
    .rd_start   (rd_start),
    .rd_decrypt (rd_decrypt),
    .rd_next    (rd_next),
    .rk_out     (rk_out),
    .rk_valid   (rk_valid),
    .rk_idx     (rk_idx),
    .rd_done    (rd_done),
    .rd_err     (rd_err)
  );

  function automatic logic [127:0] key(input int pat, input int k);
    if (pat == 0) return {32'h0, 96'(k)};
    return {32'hC0DE_0000 + 32'(k), 32'(k) * 32'h0101_0101, 64'hFEED_FACE_0000_0000 | 64'(k)};
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (ready !== 1'b0)    begin errors++; $display("FAIL reset_ready got %b exp 0", ready); end
    checks++; if (ovf !== 1'b0)      begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
    checks++; if (rk_valid !== 1'b0) begin errors++; $display("FAIL reset_rk_valid got %b exp 0", rk_valid); end
    checks++; if (rk_out !== '0)     begin errors++; $display("FAIL reset_rk_out got %h exp 0", rk_out); end
    checks++; if (rk_idx !== 4'd0)   begin errors++; $display("FAIL reset_rk_idx got %0d exp 0", rk_idx); end
    checks++; if (rd_done !== 1'b0 || rd_err !== 1'b0)
      begin errors++; $display("FAIL reset_pulses got done=%b err=%b exp 0 0", rd_done, rd_err); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_err_not_ready();
    rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    checks++; if (rd_err !== 1'b1)   begin errors++; $display("FAIL err_not_ready got %b exp 1", rd_err); end
    checks++; if (rk_valid !== 1'b0) begin errors++; $display("FAIL err_not_ready_valid got %b exp 0", rk_valid); end
    @(negedge clk);
    checks++; if (rd_err !== 1'b0)   begin errors++; $display("FAIL err_pulse_width got %b exp 0", rd_err); end
  endtask

  // Includes a beat coincident with load_start, which must be dropped.
  task automatic do_load(input int pat);
    load_start = 1'b1; skey_valid = 1'b1; skey_in = '1;
    @(negedge clk);
    load_start = 1'b0;
    checks++; if (ready !== 1'b0 || ovf !== 1'b0)
      begin errors++; $display("FAIL load_arm got ready=%b ovf=%b exp 0 0", ready, ovf); end
    for (int k = 0; k < 15; k++) begin
      skey_in = key(pat, k); skey_valid = 1'b1;
      @(negedge clk);
      if (k == 13) begin
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL load_early_ready got %b exp 0", ready); end
      end
    end
    skey_valid = 1'b0; skey_in = '0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL load_ready got %b exp 1", ready); end
  endtask

  task automatic run_pass(input logic dir, input int pat);
    int e;
    rd_start = 1'b1; rd_decrypt = dir; rd_next = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL pass_start_err got %b exp 0", rd_err); end
    for (int i = 0; i < 15; i++) begin
      e = dir ? 14 - i : i;
      checks++; if (rk_valid !== 1'b1 || rk_idx !== 4'(e) || rd_done !== 1'b0)
        begin errors++; $display("FAIL pass_step dir=%b got valid=%b idx=%0d done=%b exp 1 %0d 0", dir, rk_valid, rk_idx, rd_done, e); end
      checks++; if (rk_out !== key(pat, e))
        begin errors++; $display("FAIL pass_key idx=%0d got %h exp %h", e, rk_out, key(pat, e)); end
      @(negedge clk);
    end
    checks++; if (rd_done !== 1'b1 || rk_valid !== 1'b0)
      begin errors++; $display("FAIL pass_done got done=%b valid=%b exp 1 0", rd_done, rk_valid); end
    @(negedge clk);
    rd_next = 1'b0;
    checks++; if (rd_done !== 1'b0 || rk_valid !== 1'b0)
      begin errors++; $display("FAIL pass_after got done=%b valid=%b exp 0 0", rd_done, rk_valid); end
  endtask

  task automatic test_second_pass();
`ifdef AES_RKSTORE_ZEROIZE_EN
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL zero_ready got %b exp 0", ready); end
    checks++; if (rk_out !== '0)  begin errors++; $display("FAIL zero_rk_out got %h exp 0", rk_out); end
    rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    checks++; if (rd_err !== 1'b1 || rk_valid !== 1'b0)
      begin errors++; $display("FAIL zero_second_start got err=%b valid=%b exp 1 0", rd_err, rk_valid); end
    @(negedge clk);
`else
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL persist_ready got %b exp 1", ready); end
    run_pass(1'b0, 0);
    run_pass(1'b1, 0);
`endif
  endtask

  task automatic test_busy_err_abort();
    rd_start = 1'b1; rd_decrypt = 1'b0; rd_next = 1'b0;
    @(negedge clk);
    rd_start = 1'b1; rd_decrypt = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    checks++; if (rd_err !== 1'b1) begin errors++; $display("FAIL busy_err got %b exp 1", rd_err); end
    checks++; if (rk_valid !== 1'b1 || rk_idx !== 4'd0 || rk_out !== key(1, 0))
      begin errors++; $display("FAIL busy_err_hold got valid=%b idx=%0d key=%h", rk_valid, rk_idx, rk_out); end
    rd_next = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (rk_idx !== 4'd5 || rk_out !== key(1, 5))
      begin errors++; $display("FAIL abort_pos got idx=%0d exp 5", rk_idx); end
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0; rd_next = 1'b0;
    checks++; if (rk_valid !== 1'b0 || rd_done !== 1'b0 || ready !== 1'b0)
      begin errors++; $display("FAIL abort got valid=%b done=%b ready=%b exp 0 0 0", rk_valid, rd_done, ready); end
    @(negedge clk);
    checks++; if (rd_done !== 1'b0) begin errors++; $display("FAIL abort_no_done got %b exp 0", rd_done); end
  endtask

  task automatic test_ovf();
    skey_valid = 1'b1; skey_in = '1;
    @(negedge clk);
    skey_valid = 1'b0; skey_in = '0;
    checks++; if (ovf !== 1'b1 || ready !== 1'b1)
      begin errors++; $display("FAIL ovf_set got ovf=%b ready=%b exp 1 1", ovf, ready); end
    @(negedge clk);
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", ovf); end
    rd_start = 1'b1; rd_decrypt = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    checks++; if (rk_idx !== 4'd14 || rk_out !== key(0, 14))
      begin errors++; $display("FAIL ovf_mem14 got idx=%0d key=%h exp 14 %h", rk_idx, rk_out, key(0, 14)); end
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    checks++; if (ovf !== 1'b0 || ready !== 1'b0 || rk_valid !== 1'b0)
      begin errors++; $display("FAIL ovf_clear got ovf=%b ready=%b valid=%b exp 0 0 0", ovf, ready, rk_valid); end
  endtask

  task automatic test_async_reset();
    do_load(1);
    rd_start = 1'b1; rd_decrypt = 1'b0; rd_next = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (rk_valid !== 1'b0 || rk_idx !== 4'd0 || rk_out !== '0 || ready !== 1'b0)
      begin errors++; $display("FAIL async_reset got valid=%b idx=%0d key=%h ready=%b", rk_valid, rk_idx, rk_out, ready); end
    rd_next = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    // Beats without load_start are ignored in EMPTY.
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0; skey_valid = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (ready !== 1'b0 || ovf !== 1'b0 || rk_valid !== 1'b0 || rd_done !== 1'b0 || rd_err !== 1'b0)
      begin errors++; $display("FAIL async_reset_load got ready=%b ovf=%b valid=%b", ready, ovf, rk_valid); end
    @(negedge clk);
    reset = 1'b0;
    repeat (16) @(negedge clk);
    skey_valid = 1'b0;
    checks++; if (ready !== 1'b0 || ovf !== 1'b0)
      begin errors++; $display("FAIL empty_ignores_beats got ready=%b ovf=%b exp 0 0", ready, ovf); end
  endtask

  initial begin
    test_reset();
    test_err_not_ready();
    do_load(0);
    run_pass(1'b0, 0);
    test_second_pass();
    do_load(1);
    run_pass(1'b1, 1);
    do_load(1);
    test_busy_err_abort();
    do_load(0);
    test_ovf();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes256_roundkey_store.md
# aes256_roundkey_store

Capture-and-replay store for AES-256 round keys. It sits between the key-expansion engine and the cipher round datapath:
- **Capture side:** receives the 15 round keys as a stream of 128-bit beats and holds them in a register file.
- **Replay side:** hands the keys to the round datapath one per request, in forward order (encryption, keys 0..14) or reverse order (decryption, keys 14..0).

Key expansion runs once per key; the store then supports any number of encrypt/decrypt passes.

## Interface
Parameters:
- NKEYS, 15, number of round keys held (AES-256).
- KW, 128, round-key width in bits.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- load_start  in  1  pulse; discards stored keys and arms capture.
- skey_in  in  KW  round-key beat from key expansion.
- skey_valid  in  1  beat qualifier; one key per cycle while high.
- ready  out  1  all NKEYS keys captured; replay allowed.
- ovf  out  1  sticky: a beat arrived while READY; cleared by load_start.
- rd_start  in  1  pulse; begins a replay pass.
- rd_decrypt  in  1  sampled with rd_start: 0 = forward, 1 = reverse.
- rd_next  in  1  consumer accepted current key; advance.
- rk_out  out  KW  current round key (registered).
- rk_valid  out  1  rk_out holds a valid key.
- rk_idx  out  4  round number of rk_out (0..14).
- rd_done  out  1  one-cycle pulse after the last key is accepted.
- rd_err  out  1  one-cycle pulse: rd_start rejected.

## Operation
Capture FSM with three states: EMPTY, LOAD, READY.
- **EMPTY:** entered on reset. wptr=0; skey_valid is ignored.
- **load_start:** from any state, go to LOAD, set wptr=0, ready=0, ovf=0, and abort any replay pass. Stored entries are not cleared, only invalidated.
- **LOAD:**
  - Each skey_valid beat writes mem[wptr] and increments wptr.
  - The write of the beat with wptr=14 moves the FSM to READY.
  - Beat order is round 0 first.
- **READY:** skey_valid sets ovf and does not write.
- load_start and skey_valid in the same cycle: load_start wins and the beat is dropped.

Replay sequencer with two states: RIDLE and RBUSY.
- **rd_start in RIDLE with ready=1:** latch direction, set rptr = 0 (forward) or 14 (reverse), go to RBUSY.
- **rd_start with ready=0 or in RBUSY:** ignored; pulse rd_err.
- **RBUSY:**
  - rk_out = mem[rptr], rk_idx = rptr, rk_valid=1.
  - rd_next steps rptr by +1 (forward) or -1 (reverse).
  - rd_next on the final key (14 forward, 0 reverse) returns to RIDLE, pulses rd_done, and drops rk_valid.
- rd_next while rk_valid=0 is ignored.
- load_start during RBUSY: return to RIDLE, rk_valid=0, no rd_done.
- rptr is 4 bits and never wraps; it is bounded by the terminal checks above.

## Timing
- **Reset values:** ready=0, ovf=0, rk_out=0, rk_valid=0, rk_idx=0, rd_done=0, rd_err=0; mem contents zero.
- **Write latency:** beat at edge t is in mem at t+1. ready rises on the edge after the 15th beat.
- **Replay latency:** rd_start at edge t gives rk_valid=1 with the first key at t+1. rd_start is accepted in the same cycle ready first reads 1.
- **Throughput:** rd_next held high gives one key per cycle. 15 keys occupy cycles t+1..t+15; rd_done=1 in cycle t+16.
- **Read/write conflict:** capture and replay cannot overlap, because replay requires READY and load_start aborts replay.
- rd_err and rd_done are single-cycle pulses, registered.

## Configuration
- **ZEROIZE macro:** AES_RKSTORE_ZEROIZE_EN.
  - **Defined:** on load_start, and in the cycle rd_done pulses, all mem entries and rk_out are cleared to zero. After rd_done, ready drops to 0 and the FSM returns to EMPTY, so each capture allows a single pass.
  - **Undefined:** entries persist and READY allows unlimited passes.

## Structure
- **Shared package:** AES-256 constants (NKEYS=15, KW=128, last round index 14) and the state encodings for capture and replay. These are shared with the key expansion and round datapath.
- **Sub-module:** rk_regfile — a 15x128 register file with one synchronous write port, one combinational read port and a synchronous clear input (used only with ZEROIZE). The FSMs live in the top module.

## Test plan
- Reset, load_start, then 15 beats with skey_in = {32'h0, 96'hk} for k=0..14 → ready=1 on the edge after beat 15; forward rd_start with rd_next held high → rk_idx 0..14 on consecutive cycles, rd_done the cycle after idx 14.
- Same load, reverse rd_start → first rk_idx=14 with value 14, last rk_idx=0, then rd_done; rk_valid low afterwards.
- rd_start before ready and again during RBUSY → rd_err pulses each time; no change in rk_idx.
- A 16th beat after READY → ovf=1 and mem[14] unchanged; load_start → ovf=0, ready=0.
- load_start asserted at rk_idx=5 of a forward pass → rk_valid=0 next cycle, no rd_done; asserting reset mid-LOAD → all outputs at reset values immediately (asynchronous).
- With AES_RKSTORE_ZEROIZE_EN: after rd_done, ready=0 and a second rd_start gives rd_err; without the macro, a second pass replays identical keys.
